// File: rtl/trap_controller.sv
// Trap controller: picks the oldest pending exception or mret, redirects fetch,
// drains the wrong-path pipeline and owns mepc/mcause/mtval/mstatus.MIE/MPIE.
module trap_controller #(
  parameter int          FLUSH_CYCLES    = 2,
  parameter logic [31:0] MTVEC_MODE_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_misaligned,
  input  logic [31:0] if_pc,
  input  logic        id_illegal,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_instr,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_instr,
  input  logic        ex_illegal_csr,
  input  logic        ex_ebreak,
  input  logic        ex_load_misaligned,
  input  logic        ex_store_misaligned,
  input  logic        ex_ecall,
  input  logic [31:0] ex_mem_addr,
  input  logic        mret_req,
  input  logic [31:0] mtvec,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        trap_taken,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        mstatus_mie,
  output logic        mstatus_mpie,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [2:0]  DRAIN_LAST  = 3'(FLUSH_CYCLES - 1);
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  state_t      state_q, state_d;
  logic [2:0]  drain_q;
  logic        is_trap_q;
  logic [31:0] redirect_pc_q;

  logic        take_trap;
  logic        take_mret;
  logic [3:0]  cause;
  logic [31:0] src_pc;
  logic [31:0] tval;
  logic        ex_any;
  logic        accept;

  assign ex_any = ex_valid & (ex_illegal_csr | ex_ebreak | ex_ecall |
                              ex_load_misaligned | ex_store_misaligned);
  assign accept = (state_q == IDLE);

  // Priority select: EX is the oldest instruction, then mret, then ID, then IF.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause     = 4'd0;
    src_pc    = 32'h0;
    tval      = 32'h0;
    if (ex_any) begin
      take_trap = 1'b1;
      src_pc    = ex_pc;
      if (ex_illegal_csr) begin
        cause = 4'd2;
        tval  = ex_instr;
      end else if (ex_ebreak) begin
        cause = 4'd3;
      end else if (ex_ecall) begin
        cause = 4'd11;
      end else if (ex_load_misaligned) begin
        cause = 4'd4;
        tval  = ex_mem_addr;
      end else begin
        cause = 4'd6;
        tval  = ex_mem_addr;
      end
    end else if (ex_valid && mret_req) begin
      take_mret = 1'b1;
    end else if (id_illegal) begin
      take_trap = 1'b1;
      cause     = 4'd2;
      src_pc    = id_pc;
      tval      = id_instr;
    end else if (if_misaligned) begin
      take_trap = 1'b1;
      cause     = 4'd0;
      src_pc    = if_pc;
      tval      = if_pc;
    end
  end

  // State register and drain counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      state_q <= IDLE;
      drain_q <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == REDIRECT) begin
        drain_q <= DRAIN_LAST;
      end else if (state_q == DRAIN && drain_q != 3'd0) begin
        drain_q <= drain_q - 3'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (take_trap || take_mret) state_d = REDIRECT;
      REDIRECT: state_d = DRAIN;
      DRAIN:    if (drain_q == 3'd0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    trap_taken     = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    busy           = (state_q != IDLE);
    case (state_q)
      REDIRECT: begin
        trap_taken     = is_trap_q;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = redirect_pc_q;
      end
      DRAIN:   flush = 1'b1;
      default: ;
    endcase
  end

  // CSR file: software writes first, trap/mret capture afterwards so it wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mepc          <= 32'h0;
      mcause        <= 32'h0;
      mtval         <= 32'h0;
      mstatus_mie   <= 1'b0;
      mstatus_mpie  <= 1'b1;
      is_trap_q     <= 1'b0;
      redirect_pc_q <= 32'h0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CSR_MEPC:    mepc   <= csr_wdata & ~32'h3;
          CSR_MCAUSE:  mcause <= csr_wdata;
          CSR_MTVAL:   mtval  <= csr_wdata;
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          default: ;
        endcase
      end
      if (accept && take_trap) begin
        mepc          <= src_pc & ~32'h3;
        mcause        <= {28'h0, cause};
        mtval         <= tval;
        mstatus_mpie  <= mstatus_mie;
        mstatus_mie   <= 1'b0;
        is_trap_q     <= 1'b1;
        redirect_pc_q <= mtvec & MTVEC_MODE_MASK;
      end else if (accept && take_mret) begin
        // Return target is the mepc seen before any same-edge write.
        mstatus_mie   <= mstatus_mpie;
        mstatus_mpie  <= 1'b1;
        is_trap_q     <= 1'b0;
        redirect_pc_q <= mepc;
      end
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: expected redirect records are queued
// when a request is driven and compared when redirect_valid is observed.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_misaligned;
  logic [31:0] if_pc;
  logic        id_illegal;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic        ex_illegal_csr;
  logic        ex_ebreak;
  logic        ex_load_misaligned;
  logic        ex_store_misaligned;
  logic        ex_ecall;
  logic [31:0] ex_mem_addr;
  logic        mret_req;
  logic [31:0] mtvec;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        trap_taken;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        busy;

  typedef struct {
    logic        trap;
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        mie;
    logic        mpie;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  trap_controller #(.FLUSH_CYCLES(2), .MTVEC_MODE_MASK(32'hFFFF_FFFC)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_misaligned(if_misaligned), .if_pc(if_pc),
    .id_illegal(id_illegal), .id_pc(id_pc), .id_instr(id_instr),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_illegal_csr(ex_illegal_csr), .ex_ebreak(ex_ebreak),
    .ex_load_misaligned(ex_load_misaligned), .ex_store_misaligned(ex_store_misaligned),
    .ex_ecall(ex_ecall), .ex_mem_addr(ex_mem_addr), .mret_req(mret_req),
    .mtvec(mtvec), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .trap_taken(trap_taken), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic trap, input logic [31:0] pc, input logic [31:0] epc,
                      input logic [31:0] cause, input logic [31:0] tval,
                      input logic mie, input logic mpie);
    exp_t e;
    e.trap = trap; e.pc = pc; e.mepc = epc; e.mcause = cause;
    e.mtval = tval; e.mie = mie; e.mpie = mpie;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    if_misaligned = 0; if_pc = 0; id_illegal = 0; id_pc = 0; id_instr = 0;
    ex_valid = 0; ex_pc = 0; ex_instr = 0; ex_illegal_csr = 0; ex_ebreak = 0;
    ex_load_misaligned = 0; ex_store_misaligned = 0; ex_ecall = 0;
    ex_mem_addr = 0; mret_req = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
  endtask

  // Let the current input set be sampled by one rising edge, then release it.
  task automatic fire();
    @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  // Monitor: every redirect must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && redirect_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_redirect", 32'h1, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("trap_taken",   {31'h0, trap_taken},   {31'h0, mon_e.trap});
        check("redir_flush",  {31'h0, flush},        32'h1);
        check("redirect_pc",  redirect_pc,           mon_e.pc);
        check("mepc",         mepc,                  mon_e.mepc);
        check("mcause",       mcause,                mon_e.mcause);
        check("mtval",        mtval,                 mon_e.mtval);
        check("mie",          {31'h0, mstatus_mie},  {31'h0, mon_e.mie});
        check("mpie",         {31'h0, mstatus_mpie}, {31'h0, mon_e.mpie});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int flush_len;
    clear_inputs();
    mtvec   = 32'h0000_0104;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'h0, busy},         32'h0);
    check("rst_flush", {31'h0, flush},        32'h0);
    check("rst_rv",    {31'h0, redirect_valid}, 32'h0);
    check("rst_mepc",  mepc,                  32'h0);
    check("rst_mie",   {31'h0, mstatus_mie},  32'h0);
    check("rst_mpie",  {31'h0, mstatus_mpie}, 32'h1);
    reset_n = 1;
    @(negedge clk);

    // 1: illegal CSR in EX, flush spans redirect + two drain cycles
    push(1, 32'h104, 32'hE8, 32'd2, 32'hC000_1073, 0, 0);
    ex_valid = 1; ex_illegal_csr = 1; ex_pc = 32'hE8; ex_instr = 32'hC000_1073;
    fire();
    flush_len = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (flush) flush_len++;
      else break;
    end
    check("flush_len", flush_len, 3);

    // 2: ecall beats id_illegal; held id_illegal re-traps after drain
    push(1, 32'h104, 32'h200, 32'd11, 32'h0, 0, 0);
    push(1, 32'h104, 32'h204, 32'd2, 32'h0000_FFFF, 0, 0);
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h200; ex_instr = 32'h0000_0073;
    id_illegal = 1; id_pc = 32'h204; id_instr = 32'h0000_FFFF;
    @(posedge clk);
    #1 begin ex_valid = 0; ex_ecall = 0; ex_pc = 0; ex_instr = 0; end
    wait_idle();
    check("retrap_pending", sb.size(), 1);
    @(posedge clk);
    #1 clear_inputs();
    wait_idle();

    // 3: EX request without ex_valid is ignored; fetch misaligned, masked mtvec
    ex_illegal_csr = 1; ex_pc = 32'h500;
    fire();
    @(negedge clk);
    check("exv0_ignored", {31'h0, busy}, 32'h0);
    mtvec = 32'h0000_0107;
    push(1, 32'h104, 32'h300, 32'd0, 32'h302, 0, 0);
    if_misaligned = 1; if_pc = 32'h302;
    fire();
    wait_idle();
    mtvec = 32'h0000_0104;

    // 4: enable MIE, trap, then mret back to mepc
    csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'h8;
    fire();
    @(negedge clk);
    check("csr_mie_set",  {31'h0, mstatus_mie},  32'h1);
    check("csr_mpie_clr", {31'h0, mstatus_mpie}, 32'h0);
    push(1, 32'h104, 32'h1F0, 32'd11, 32'h0, 0, 1);
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h1F0;
    fire();
    wait_idle();
    push(0, 32'h1F0, 32'h1F0, 32'd11, 32'h0, 1, 1);
    ex_valid = 1; mret_req = 1; ex_pc = 32'h300;
    fire();
    wait_idle();

    // 5: trap capture beats a same-edge mepc write; lone write masks low bits
    push(1, 32'h104, 32'h40, 32'd3, 32'h0, 0, 1);
    ex_valid = 1; ex_ebreak = 1; ex_pc = 32'h40;
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h1234_5677;
    fire();
    wait_idle();
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h1234_5677;
    fire();
    check("csr_mepc_wr", mepc, 32'h1234_5674);
    @(negedge clk);

    // 6: reset during drain, then a trap on the first cycle out of reset
    push(1, 32'h104, 32'h80, 32'd4, 32'h1001, 0, 0);
    ex_valid = 1; ex_load_misaligned = 1; ex_pc = 32'h80; ex_mem_addr = 32'h1001;
    fire();
    @(posedge clk);
    #1 reset_n = 0;
    @(posedge clk);
    #1;
    check("rst2_busy",  {31'h0, busy},         32'h0);
    check("rst2_flush", {31'h0, flush},        32'h0);
    check("rst2_mepc",  mepc,                  32'h0);
    check("rst2_mpie",  {31'h0, mstatus_mpie}, 32'h1);
    push(1, 32'h104, 32'h90, 32'd6, 32'h2002, 0, 0);
    reset_n = 1;
    ex_valid = 1; ex_store_misaligned = 1; ex_pc = 32'h90; ex_mem_addr = 32'h2002;
    fire();
    wait_idle();

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sits directly downstream of the EX-stage exception detection in rv32i_core_pipelined.
- Collects exception requests from IF, ID and EX, then selects the oldest, highest-priority one.
- Captures mepc/mcause/mtval, updates mstatus MIE/MPIE, flushes the pipeline and redirects fetch to mtvec.
- Handles mret by redirecting fetch to mepc; owns the trap-related M-mode CSRs.

Parameters:
- FLUSH_CYCLES, 2: cycles after a redirect during which all new exception/mret requests are ignored (wrong-path drain); legal range 1-7.
- MTVEC_MODE_MASK, 32'hFFFF_FFFC: mask applied to mtvec to form the trap target (direct mode only).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- if_misaligned  in  1  fetch address misaligned (cause 0)
- if_pc  in  32  PC of IF instruction
- id_illegal  in  1  illegal instruction decoded (cause 2)
- id_pc  in  32  PC in ID
- id_instr  in  32  instruction word in ID
- ex_valid  in  1  EX slot holds a real instruction
- ex_pc  in  32  PC in EX
- ex_instr  in  32  instruction word in EX
- ex_illegal_csr  in  1  illegal CSR access (cause 2)
- ex_ebreak  in  1  cause 3
- ex_load_misaligned  in  1  cause 4
- ex_store_misaligned  in  1  cause 6
- ex_ecall  in  1  cause 11
- ex_mem_addr  in  32  effective address for misaligned faults
- mret_req  in  1  mret in EX (qualified by ex_valid)
- mtvec  in  32  trap vector CSR value
- csr_we  in  1  software CSR write strobe
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR write data
- trap_taken  out  1  one-cycle pulse on trap entry
- flush  out  1  kill IF/ID/EX
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  32  redirect target
- mepc  out  32  mepc CSR
- mcause  out  32  mcause CSR
- mtval  out  32  mtval CSR
- mstatus_mie  out  1  mstatus.MIE
- mstatus_mpie  out  1  mstatus.MPIE
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n low at posedge): state IDLE, drain counter 0; all outputs 0 except mstatus_mpie=1.
- Reset mid-drain or mid-redirect aborts immediately to IDLE.
- States:
  - IDLE: scan for a pending trap or mret.
  - REDIRECT: 1 cycle. trap_taken (trap only), flush and redirect_valid are all high.
  - DRAIN: FLUSH_CYCLES cycles. flush is held high, redirect_valid=0.
  - DRAIN then returns to IDLE.
- Latency: a request sampled in IDLE at edge N is registered. REDIRECT outputs are visible in cycle N+1, and the CSRs are updated at that same edge.
- Selection (oldest first), evaluated only in IDLE:
  1. EX, only if ex_valid=1, in order: ex_illegal_csr(2) > ex_ebreak(3) > ex_ecall(11) > ex_load_misaligned(4) > ex_store_misaligned(6).
  2. Then mret_req, only if ex_valid=1 and no EX exception.
  3. Then id_illegal(2).
  4. Then if_misaligned(0).
  5. Lower-ranked sources are dropped; they re-raise after the refetch.
- Trap capture:
  - mepc <= source PC with bits[1:0] forced to 0.
  - mcause <= {1'b0, 27'b0, code}.
  - mtval <= ex_instr / id_instr for illegal; ex_mem_addr for misaligned load/store; if_pc for fetch misaligned; 0 for ecall/ebreak.
  - mstatus_mpie <= mstatus_mie; mstatus_mie <= 0.
  - redirect_pc = mtvec & MTVEC_MODE_MASK.
- mret: redirect_pc = mepc (the value before any same-edge update); mstatus_mie <= mstatus_mpie; mstatus_mpie <= 1; trap_taken stays 0.
- CSR writes (csr_we, any state):
  - 0x341: mepc <= wdata & ~3.
  - 0x342: mcause <= wdata.
  - 0x343: mtval <= wdata.
  - 0x300: MIE <= wdata[3], MPIE <= wdata[7].
- Simultaneous CSR write and trap capture on the same edge: trap capture wins for every overlapping field.
- Requests arriving in REDIRECT/DRAIN are ignored, including when held high.
- A request held continuously re-traps on the first IDLE cycle after DRAIN.

Test Plan:
1. ex_valid=1, ex_illegal_csr=1, ex_pc=0x0000_00E8, ex_instr=0xC000_1073, mtvec=0x0000_0104 -> next cycle: trap_taken=1, redirect_pc=0x104, mepc=0xE8, mcause=2, mtval=0xC000_1073, flush high for 1+FLUSH_CYCLES=3 cycles.
2. Same cycle ex_ecall=1 (ex_pc=0x200) and id_illegal=1 (id_pc=0x204) -> mcause=11, mepc=0x200, mtval=0. id_illegal held through DRAIN -> second trap with mcause=2, mepc=0x204 on the first IDLE cycle.
3. ex_valid=0 with ex_illegal_csr=1, and separately if_misaligned=1 with if_pc=0x302 -> EX request ignored; trap mcause=0, mepc=0x300, mtval=0x302.
4. Sequence: MIE=1 via csr write 0x300 (wdata=0x8), then trap, then mret_req with mepc=0x1F0 -> after trap MIE=0/MPIE=1; after mret redirect_pc=0x1F0, trap_taken=0, MIE=1, MPIE=1.
5. csr_we to 0x341 with wdata=0x1234_5677 in the same cycle as an ex_ebreak at pc 0x40 -> mepc=0x40. Later a lone write of the same value -> mepc=0x1234_5674.
6. reset_n driven low during DRAIN -> next cycle busy=0, flush=0, mepc=0, mstatus_mpie=1; a new trap is accepted on the first cycle after reset_n rises.
